// File: rtl/csr_exec_unit_if.sv
// Bundle between the execute stage and the CSR execute unit. It carries the instruction
// fields toward the unit, and carries the CSR file write port and the rd return back.
interface csr_exec_unit_if;
  logic        stall;
  logic        valid_x;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic        retire;

  logic        csr_we;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_din;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        illegal;
  logic [31:0] tohost;

  // Pipeline side: drives instruction fields and consumes results.
  modport master (
    output stall, valid_x, csr_op, csr_addr, rs1_idx, rs1_data, retire,
    input  csr_we, csr_addr_o, csr_din, csr_rdata, csr_rvalid, illegal, tohost
  );

  // CSR execute unit side.
  modport slave (
    input  stall, valid_x, csr_op, csr_addr, rs1_idx, rs1_data, retire,
    output csr_we, csr_addr_o, csr_din, csr_rdata, csr_rvalid, illegal, tohost
  );
endinterface

// File: rtl/csr_exec_unit.sv
// Zicsr execute unit. It performs the read-modify-write against local shadows of the
// writable CSRs and against the cycle and instret counters. It then issues a one-cycle
// write pulse to the CSR register file and returns the old value for rd writeback.
module csr_exec_unit #(
  parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
  parameter logic [11:0] SCRATCH_ADDR = 12'h340,
  parameter int unsigned CNT_WIDTH    = 64
) (
  input  logic           clk,
  input  logic           rst,
  csr_exec_unit_if.slave bus
);
  localparam int unsigned HI_W = CNT_WIDTH - 32;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // User-level counter views are read-only; machine-level views of the same counters are writable.
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  // funct3[1:0] selects the operation; funct3[2] selects the immediate (zimm) source.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } op_kind_e;

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [31:0]          tohost_q, tohost_d;
  logic [31:0]          scratch_q, scratch_d;

  logic        we_q, rvalid_q, illegal_q;
  logic [11:0] addr_q;
  logic [31:0] din_q, rdata_q;

  op_kind_e    op_kind;
  logic        accept, do_write, is_ro, wr_ok, illegal_d;
  logic [31:0] src, old_val, new_val;

  // Decode the instruction, select the old value and form the new value.
  always_comb begin
    // NOTE: each signal gets a default first, so no path through the if/case chain can infer a latch.
    op_kind = op_kind_e'(bus.csr_op[1:0]);
    src     = bus.csr_op[2] ? {27'd0, bus.rs1_idx} : bus.rs1_data;
    old_val = 32'd0;
    is_ro   = 1'b0;

    if (bus.csr_addr == TOHOST_ADDR) begin
      old_val = tohost_q;
    end else if (bus.csr_addr == SCRATCH_ADDR) begin
      old_val = scratch_q;
    end else begin
      case (bus.csr_addr)
        ADDR_CYCLE:     begin old_val = cycle_q[31:0];                    is_ro = 1'b1; end
        ADDR_CYCLEH:    begin old_val = 32'(cycle_q[CNT_WIDTH-1:32]);     is_ro = 1'b1; end
        ADDR_INSTRET:   begin old_val = instret_q[31:0];                  is_ro = 1'b1; end
        ADDR_INSTRETH:  begin old_val = 32'(instret_q[CNT_WIDTH-1:32]);   is_ro = 1'b1; end
        ADDR_MCYCLE:    old_val = cycle_q[31:0];
        ADDR_MCYCLEH:   old_val = 32'(cycle_q[CNT_WIDTH-1:32]);
        ADDR_MINSTRET:  old_val = instret_q[31:0];
        ADDR_MINSTRETH: old_val = 32'(instret_q[CNT_WIDTH-1:32]);
        default:        old_val = 32'd0;
      endcase
    end

    case (op_kind)
      OP_RW:   new_val = src;
      OP_RS:   new_val = old_val | src;
      OP_RC:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase

    // Set/clear with rs1=x0 (or zimm=0) is a pure read.
    do_write  = (op_kind == OP_RW) || (bus.rs1_idx != 5'd0);
    accept    = bus.valid_x && !bus.stall && (op_kind != OP_NONE);
    wr_ok     = accept && do_write && !is_ro;
    illegal_d = accept && do_write && is_ro;
  end

  // Next state for the shadows and counters. A counter write replaces the addressed half
  // and takes precedence over that cycle's increment.
  always_comb begin
    tohost_d  = tohost_q;
    scratch_d = scratch_q;
    cycle_d   = cycle_q + CNT_ONE;
    instret_d = bus.retire ? instret_q + CNT_ONE : instret_q;

    if (wr_ok) begin
      if (bus.csr_addr == TOHOST_ADDR) begin
        tohost_d = new_val;
      end else if (bus.csr_addr == SCRATCH_ADDR) begin
        scratch_d = new_val;
      end else begin
        case (bus.csr_addr)
          ADDR_MCYCLE:    cycle_d   = {cycle_q[CNT_WIDTH-1:32], new_val};
          ADDR_MCYCLEH:   cycle_d   = {new_val[HI_W-1:0], cycle_q[31:0]};
          ADDR_MINSTRET:  instret_d = {instret_q[CNT_WIDTH-1:32], new_val};
          ADDR_MINSTRETH: instret_d = {new_val[HI_W-1:0], instret_q[31:0]};
          default:        ;
        endcase
      end
    end
  end

  // Register the state and the one-cycle result pulses; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
      tohost_q  <= '0;
      scratch_q <= '0;
      we_q      <= 1'b0;
      rvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the pre-edge values, so the order of these lines does not matter.
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      tohost_q  <= tohost_d;
      scratch_q <= scratch_d;
      we_q      <= wr_ok;
      rvalid_q  <= accept;
      illegal_q <= illegal_d;
      addr_q    <= accept ? bus.csr_addr : 12'd0;
      din_q     <= accept ? new_val : 32'd0;
      rdata_q   <= accept ? old_val : 32'd0;
    end
  end

  assign bus.csr_we     = we_q;
  assign bus.csr_addr_o = addr_q;
  assign bus.csr_din    = din_q;
  assign bus.csr_rdata  = rdata_q;
  assign bus.csr_rvalid = rvalid_q;
  assign bus.illegal    = illegal_q;
  assign bus.tohost     = tohost_q;
endmodule
